// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state type and default geometry for the tag/valid array.
package cache_pkg;
  typedef enum logic {IDLE, FLUSH} state_t;
  localparam int LINE_DEF  = 128;
  localparam int WAYS_DEF  = 2;
  localparam int TAG_W_DEF = 20;
endpackage

// File: rtl/cache_tagv_array_if.sv
// cache_tagv_array_if: lookup, write and flush signals of the tag/valid array.
interface cache_tagv_array_if #(
  parameter int LINE  = 128,
  parameter int WAYS  = 2,
  parameter int TAG_W = 20
);
  logic                      en;
  logic [$clog2(LINE)-1:0]   index;
  logic [WAYS-1:0]           tag_wen;
  logic [WAYS-1:0]           val_wen;
  logic [TAG_W-1:0]          wtag;
  logic                      wvalid;
  logic [TAG_W-1:0]          cmp_tag;
  logic                      flush_req;
  logic                      flush_busy;
  logic [WAYS*(TAG_W+1)-1:0] back;
  logic [WAYS-1:0]           hit;
  modport master (output en, index, tag_wen, val_wen, wtag, wvalid, cmp_tag, flush_req,
                  input flush_busy, back, hit);
  modport slave  (input en, index, tag_wen, val_wen, wtag, wvalid, cmp_tag, flush_req,
                  output flush_busy, back, hit);
endinterface

// File: rtl/cache_tagv_way.sv
// cache_tagv_way: one way's unreset tag RAM plus resettable valid flops with per-set clear.
// TAGV_BYPASS_EN forwards same-cycle write data onto the read port field by field.
module cache_tagv_way #(
  parameter int LINE  = 128,
  parameter int TAG_W = 20
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    tag_we,
  input  logic                    val_we,
  input  logic [$clog2(LINE)-1:0] idx,
  input  logic [TAG_W-1:0]        wtag,
  input  logic                    wvalid,
  input  logic                    clr,
  input  logic [$clog2(LINE)-1:0] clr_idx,
  output logic [TAG_W:0]          rd
);
  logic [TAG_W-1:0] mem [LINE];
  logic [LINE-1:0]  val_q;
  always_ff @(posedge clk)
    if (tag_we) mem[idx] <= wtag;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) val_q <= '0;
    else if (clr) val_q[clr_idx] <= 1'b0;
    else if (val_we) val_q[idx] <= wvalid;
`ifdef TAGV_BYPASS_EN
  assign rd = {tag_we ? wtag : mem[idx], val_we ? wvalid : val_q[idx]};
`else
  assign rd = {mem[idx], val_q[idx]};
`endif
endmodule

// File: rtl/cache_tagv_array.sv
// cache_tagv_array: WAYS-way tag/valid array with registered lookup, hit compare and flush sweep.
// TAGV_BYPASS_EN (in cache_tagv_way) selects write-through on same-index read/write.
module cache_tagv_array
  import cache_pkg::*;
#(
  parameter int LINE  = LINE_DEF,
  parameter int WAYS  = WAYS_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input logic clk,
  input logic resetn,
  cache_tagv_array_if.slave bus
);
  localparam int IW = $clog2(LINE);
  localparam int FW = TAG_W + 1;
  state_t              state_q, state_d;
  logic [IW-1:0]       cnt_q, cnt_d;
  logic [WAYS*FW-1:0]  back_q, back_d, rdata;
  logic [TAG_W-1:0]    cmp_q, cmp_d;
  logic                idle, wr_ok, rd_en;
  assign idle  = state_q == IDLE;
  assign wr_ok = idle & ~bus.flush_req;
  assign rd_en = idle & bus.en;
  always_comb begin
    state_d = idle ? (bus.flush_req ? FLUSH : IDLE) : (cnt_q == IW'(LINE-1) ? IDLE : FLUSH);
    cnt_d   = idle ? '0 : cnt_q + 1'b1;
    back_d  = rd_en ? rdata : back_q;
    cmp_d   = rd_en ? bus.cmp_tag : cmp_q;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      back_q  <= '0;
      cmp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      back_q  <= back_d;
      cmp_q   <= cmp_d;
    end
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_tagv_way #(.LINE(LINE), .TAG_W(TAG_W)) u_way (
      .clk     (clk),
      .resetn  (resetn),
      .tag_we  (wr_ok & bus.tag_wen[w]),
      .val_we  (wr_ok & bus.val_wen[w]),
      .idx     (bus.index),
      .wtag    (bus.wtag),
      .wvalid  (bus.wvalid),
      .clr     (~idle),
      .clr_idx (cnt_q),
      .rd      (rdata[w*FW +: FW])
    );
    assign bus.hit[w] = back_q[w*FW] & (back_q[w*FW+1 +: TAG_W] == cmp_q);
  end
  assign bus.back       = back_q;
  assign bus.flush_busy = ~idle;
endmodule

// File: tb/tb_cache_tagv_array.sv
// tb_cache_tagv_array: directed self-checking bench for cache_tagv_array (LINE=128, WAYS=2, TAG_W=20).
module tb_cache_tagv_array;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int failures = 0;
  int n;
  cache_tagv_array_if #(.LINE(128), .WAYS(2), .TAG_W(20)) bif ();
  cache_tagv_array #(.LINE(128), .WAYS(2), .TAG_W(20)) dut (.clk(clk), .resetn(resetn), .bus(bif));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input logic [1:0] tw, input logic [1:0] vw,
                    input logic [19:0] t, input logic v);
    bif.index = 7'(idx); bif.tag_wen = tw; bif.val_wen = vw; bif.wtag = t; bif.wvalid = v;
    tick();
    bif.tag_wen = '0; bif.val_wen = '0;
  endtask

  task automatic rd(input int idx, input logic [19:0] c);
    bif.index = 7'(idx); bif.cmp_tag = c; bif.en = 1'b1;
    tick();
    bif.en = 1'b0;
  endtask

  task automatic wait_flush(input string tag);
    n = 0;
    while (bif.flush_busy && n < 1000) begin
      n++;
      tick();
    end
    chk(tag, 64'(n), 64'd128);
  endtask

  initial begin
    bif.en = 0; bif.index = '0; bif.tag_wen = '0; bif.val_wen = '0;
    bif.wtag = '0; bif.wvalid = 0; bif.cmp_tag = '0; bif.flush_req = 0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    // known tags at set 5 so the post-reset read is fully defined
    wr(5, 2'b11, 2'b00, 20'h0, 1'b0);
    resetn = 1'b0;
    #1;
    chk("reset_busy", 64'(bif.flush_busy), 64'd0);
    chk("reset_back", 64'(bif.back), 64'd0);
    chk("reset_hit", 64'(bif.hit), 64'd0);
    tick();
    resetn = 1'b1;
    tick();
    rd(5, 20'h12345);
    chk("rd5_back", 64'(bif.back), 64'd0);
    chk("rd5_hit", 64'(bif.hit), 64'd0);

    wr(7, 2'b10, 2'b10, 20'hABCDE, 1'b1);
    rd(7, 20'hABCDE);
    chk("w1_hit", 64'(bif.hit), 64'b10);
    chk("w1_field", 64'(bif.back[41:21]), 64'({20'hABCDE, 1'b1}));
    wr(7, 2'b01, 2'b01, 20'h00001, 1'b1);
    rd(7, 20'h00001);
    chk("w0_hit", 64'(bif.hit), 64'b01);
    chk("w0_field", 64'(bif.back[20:0]), 64'({20'h00001, 1'b1}));
    bif.index = 7'd3; bif.cmp_tag = 20'hABCDE;
    tick();
    chk("hold_hit", 64'(bif.hit), 64'b01);
    chk("hold_field", 64'(bif.back[20:0]), 64'({20'h00001, 1'b1}));
    wr(7, 2'b00, 2'b10, 20'h0, 1'b0);
    rd(7, 20'hABCDE);
    chk("valonly_hit", 64'(bif.hit), 64'b00);
    chk("valonly_field", 64'(bif.back[41:21]), 64'({20'hABCDE, 1'b0}));

    wr(3, 2'b01, 2'b01, 20'h22222, 1'b1);
    bif.index = 7'd3; bif.en = 1; bif.cmp_tag = 20'h11111; bif.tag_wen = 2'b01; bif.wtag = 20'h11111;
    tick();
    bif.en = 0; bif.tag_wen = '0;
`ifdef TAGV_BYPASS_EN
    chk("rw_same_tag", 64'(bif.back[20:1]), 64'h11111);
    chk("rw_same_hit", 64'(bif.hit), 64'b01);
`else
    chk("rw_same_tag", 64'(bif.back[20:1]), 64'h22222);
    chk("rw_same_hit", 64'(bif.hit), 64'b00);
`endif
    rd(3, 20'h11111);
    chk("rw_after_hit", 64'(bif.hit), 64'b01);
    chk("rw_after_tag", 64'(bif.back[20:1]), 64'h11111);

    wr(0, 2'b01, 2'b01, 20'hAAAAA, 1'b1);
    wr(64, 2'b01, 2'b01, 20'hBBBBB, 1'b1);
    wr(127, 2'b01, 2'b01, 20'hCCCCC, 1'b1);
    bif.flush_req = 1;
    tick();
    bif.flush_req = 0;
    chk("flush_busy_on", 64'(bif.flush_busy), 64'd1);
    // traffic during the sweep must be ignored
    bif.en = 1; bif.index = 7'd0; bif.cmp_tag = 20'hAAAAA;
    bif.tag_wen = 2'b11; bif.val_wen = 2'b11; bif.wtag = 20'h0; bif.wvalid = 1;
    bif.flush_req = 1;
    wait_flush("flush_len");
    bif.en = 0; bif.tag_wen = '0; bif.val_wen = '0; bif.flush_req = 0;
    chk("flush_back_hold", 64'(bif.back[20:0]), 64'({20'h11111, 1'b1}));
    chk("flush_hit_hold", 64'(bif.hit), 64'b01);
    tick();
    chk("flush_req_not_queued", 64'(bif.flush_busy), 64'd0);
    rd(0, 20'hAAAAA);
    chk("fl0_hit", 64'(bif.hit), 64'b00);
    chk("fl0_field", 64'(bif.back[20:0]), 64'({20'hAAAAA, 1'b0}));
    rd(64, 20'hBBBBB);
    chk("fl64_hit", 64'(bif.hit), 64'b00);
    chk("fl64_field", 64'(bif.back[20:0]), 64'({20'hBBBBB, 1'b0}));
    rd(127, 20'hCCCCC);
    chk("fl127_hit", 64'(bif.hit), 64'b00);
    chk("fl127_field", 64'(bif.back[20:0]), 64'({20'hCCCCC, 1'b0}));

    bif.flush_req = 1; bif.index = 7'd9; bif.tag_wen = 2'b01; bif.val_wen = 2'b01;
    bif.wtag = 20'h99999; bif.wvalid = 1;
    tick();
    bif.flush_req = 0; bif.tag_wen = '0; bif.val_wen = '0;
    wait_flush("flush_wr_len");
    rd(9, 20'h99999);
    chk("fl_wr_dropped_valid", 64'(bif.back[0]), 64'd0);
    chk("fl_wr_dropped_hit", 64'(bif.hit), 64'b00);

    wr(100, 2'b01, 2'b01, 20'hDDDDD, 1'b1);
    wr(10, 2'b10, 2'b10, 20'hEEEEE, 1'b1);
    bif.flush_req = 1;
    tick();
    bif.flush_req = 0;
    repeat (40) tick();
    chk("abort_busy_before", 64'(bif.flush_busy), 64'd1);
    resetn = 1'b0;
    #1;
    chk("abort_busy_async", 64'(bif.flush_busy), 64'd0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    chk("abort_busy_after", 64'(bif.flush_busy), 64'd0);
    rd(100, 20'hDDDDD);
    chk("abort100_hit", 64'(bif.hit), 64'b00);
    chk("abort100_field", 64'(bif.back[20:0]), 64'({20'hDDDDD, 1'b0}));
    rd(10, 20'hEEEEE);
    chk("abort10_field", 64'(bif.back[41:21]), 64'({20'hEEEEE, 1'b0}));
    bif.flush_req = 1;
    tick();
    bif.flush_req = 0;
    wait_flush("reflush_len");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
